pad_stream_gen: RTL and testbench
=================================

// Module: pad_stream_gen
// PURPOSE
//   Producer side of the padded pixel stream that the 3x3 convolution cores consume.
//   Accepts a raw raster of IMG_H x IMG_W 8-bit pixels over valid/ready.
//   Emits a zero-padded raster of (IMG_H+2*PAD) rows x (IMG_W+2*PAD) columns:
//   PAD zero rows top and bottom, PAD zero columns left and right.
//   Sits between the pixel source and coefficient conv engines; frames run back to back.
// PARAMETERS
//   IMG_W  512  active pixels per input row
//   IMG_H  512  active rows per input frame
//   PAD    1    border width in pixels; legal range 1..4
// PORTS
//   clk      in   1  clock
//   reset    in   1  synchronous, active-high
//   i_valid  in   1  upstream pixel valid
//   o_ready  out  1  upstream may transfer (transfer = i_valid && o_ready)
//   i_x      in   8  upstream pixel
//   o_valid  out  1  padded-stream beat valid (registered)
//   i_ready  in   1  downstream accepts beat
//   o_y      out  8  padded-stream pixel (registered)
//   o_last   out  1  high with final beat of each padded frame (registered)
// BEHAVIOUR
//   Reset: o_valid=0, o_y=0, o_last=0, state=S_IDLE, row/col counters=0.
//   o_ready=0 while reset is high.
//   advance = ~o_valid | i_ready; the output register loads only when advance=1.
//   o_valid/o_y/o_last hold stable while o_valid && !i_ready.
//   o_ready = advance && (state==S_BODY) (combinational); no input is taken in any other state.
//   Each beat is produced in a cycle with advance=1. In S_BODY a beat also requires i_valid=1.
//   Beat produced in cycle N appears on o_y in cycle N+1 (latency 1). No bubbles when downstream is always ready.
//   FSM:
//     S_IDLE   -> S_TOP on i_valid=1 (no consume, no beat).
//                 S_IDLE emits nothing; a frame starts only once data is present.
//     S_TOP    emits PAD*(IMG_W+2*PAD) zeros -> S_LEFT
//     S_LEFT   emits PAD zeros -> S_BODY
//     S_BODY   emits IMG_W input pixels (pass-through) -> S_RIGHT
//     S_RIGHT  emits PAD zeros
//              -> S_LEFT if active rows remain
//              -> S_BOTTOM after row IMG_H-1
//     S_BOTTOM emits PAD*(IMG_W+2*PAD) zeros -> S_IDLE
//   Counters:
//     col: $clog2(IMG_W+2*PAD) bits, 0..IMG_W+2*PAD-1, wraps to 0 on last column.
//     row: $clog2(IMG_H+2*PAD) bits, wraps to 0 after the last padded row.
//   o_last=1 only on beat (row=IMG_H+2*PAD-1, col=IMG_W+2*PAD-1).
//   Input stalls in S_BODY (i_valid=0) insert bubbles. Column position never advances without a beat.
//   Downstream stall in any state freezes the FSM and counters.
//   A stall spanning the S_BODY->S_RIGHT edge drops nothing.
//   Back-to-back frames:
//     after S_BOTTOM, S_IDLE is left on the next cycle when i_valid=1.
//     Exactly one idle cycle between frames.
//   Reset mid-frame:
//     partial frame discarded; next frame restarts at S_TOP.
//     An input beat presented in the reset cycle is not consumed.
//   Pixel values are passed unmodified; no arithmetic on data.
// STRUCTURE
//   conv_pkg (shared):
//     typedef logic [7:0] pixel_t;
//     typedef enum {S_IDLE,S_TOP,S_LEFT,S_BODY,S_RIGHT,S_BOTTOM} pad_state_t;
//     function stream_w(img_w,pad) = img_w+2*pad.
//   No sub-module: FSM, counters and output register live in this module.
//   The output stage uses the same advance/stall form as the conv cores.
// TESTING (IMG_W=4, IMG_H=2, PAD=1 unless stated)
//   1. Single frame 1..8, i_ready=1 always:
//      24 beats = 0,0,0,0,0,0, 0,1,2,3,4,0, 0,5,6,7,8,0, 0,0,0,0,0,0
//      o_last on beat 24 only.
//   2. Same frame, i_ready toggling 1010...:
//      identical 24-beat sequence; o_y/o_last never change while o_valid && !i_ready.
//   3. Input gaps (i_valid low 3 cycles after pixels 2 and 6):
//      sequence unchanged; o_ready=0 outside S_BODY; no pixel lost or duplicated.
//   4. Two frames back to back (1..8 then 9..16):
//      48 beats, exactly one idle cycle between them.
//      o_last twice; second frame rows read 0,9,10,11,12,0 / 0,13,14,15,16,0.
//   5. Reset asserted at beat 10 of frame 1:
//      next cycle o_valid=0, o_last=0.
//      A new frame 21..28 then yields the full 24-beat padded pattern.
//   6. PAD=2, IMG_W=3, IMG_H=1, pixels 7,8,9:
//      35 beats (5x7); only row 2 reads 0,0,7,8,9,0,0; all other rows all-zero.

Source files
------------

// File: rtl/pad_stream_gen_pkg.sv
// Shared types for the padded pixel stream producer.
//   pixel_t      8-bit pixel as carried on both sides of the padder
//   pad_state_t  frame-walk states of the padder FSM
//   stream_w()   padded extent of one image dimension
package pad_stream_gen_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_LEFT,
        S_BODY,
        S_RIGHT,
        S_BOTTOM
    } pad_state_t;

    // Padded size of one dimension: active pixels plus a border on each side.
    function automatic int unsigned stream_w(input int unsigned img_w, input int unsigned pad);
        return img_w + 2 * pad;
    endfunction

endpackage

// File: rtl/pad_stream_gen_if.sv
// Handshake bundle around the padder.
//   i_valid / o_ready / i_x          raw pixel input (transfer = i_valid && o_ready)
//   o_valid / i_ready / o_y / o_last padded output beat (transfer = o_valid && i_ready)
// master: the padder's view.  slave: the surrounding source/sink's view.
interface pad_stream_gen_if;
    import pad_stream_gen_pkg::*;

    logic   i_valid;
    logic   o_ready;
    pixel_t i_x;
    logic   o_valid;
    logic   i_ready;
    pixel_t o_y;
    logic   o_last;

    modport master (
        input  i_valid,
        input  i_x,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_y,
        output o_last
    );

    modport slave (
        output i_valid,
        output i_x,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_y,
        input  o_last
    );

endinterface

// File: rtl/pad_stream_gen.sv
// Zero-padding stream generator.
// Takes an IMG_H x IMG_W raster of pixels and emits the (IMG_H+2*PAD) x (IMG_W+2*PAD)
// raster with PAD zero rows/columns on each border, in raster order, one beat per
// cycle when the sink is ready. Frames start only once input data is present.
// Ports:
//   clk    clock
//   reset  synchronous, active-high; discards any partial frame
//   bus    handshake bundle (master view): raw pixels in, padded beats out.
//          o_valid/o_y/o_last are registered; o_ready is combinational.
// PAD is meant to be 1..4.
module pad_stream_gen
    import pad_stream_gen_pkg::*;
#(
    parameter int unsigned IMG_W = 512,
    parameter int unsigned IMG_H = 512,
    parameter int unsigned PAD   = 1
) (
    input  logic             clk,
    input  logic             reset,
    pad_stream_gen_if.master bus
);

    localparam int unsigned STREAM_W = stream_w(IMG_W, PAD);
    localparam int unsigned STREAM_H = stream_w(IMG_H, PAD);
    localparam int unsigned COL_W    = $clog2(STREAM_W);
    localparam int unsigned ROW_W    = $clog2(STREAM_H);

    // Column/row positions at which each region ends.
    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(STREAM_W - 1);
    localparam logic [COL_W-1:0] COL_LEFT_END = COL_W'(PAD - 1);
    localparam logic [COL_W-1:0] COL_BODY_END = COL_W'(PAD + IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(STREAM_H - 1);
    localparam logic [ROW_W-1:0] ROW_TOP_END  = ROW_W'(PAD - 1);
    localparam logic [ROW_W-1:0] ROW_BODY_END = ROW_W'(PAD + IMG_H - 1);

    pad_state_t       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic   valid_q, valid_d;
    pixel_t y_q, y_d;
    logic   last_q, last_d;

    logic advance;
    logic beat;
    logic take;
    logic col_last;
    logic row_last;

    // Output register may load when empty or when its beat is being taken.
    assign advance  = ~valid_q | bus.i_ready;
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; nothing moves while the sink is stalled.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (advance) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        state_d = S_TOP;
                    end
                end
                S_TOP: begin
                    if (col_last && (row_q == ROW_TOP_END)) begin
                        state_d = S_LEFT;
                    end
                end
                S_LEFT: begin
                    if (col_q == COL_LEFT_END) begin
                        state_d = S_BODY;
                    end
                end
                S_BODY: begin
                    if (bus.i_valid && (col_q == COL_BODY_END)) begin
                        state_d = S_RIGHT;
                    end
                end
                S_RIGHT: begin
                    if (col_last) begin
                        state_d = (row_q == ROW_BODY_END) ? S_BOTTOM : S_LEFT;
                    end
                end
                S_BOTTOM: begin
                    if (col_last && row_last) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: beat generation, input handshake, next output word
    // ------------------------------------------------------------------
    always_comb begin
        beat = 1'b0;
        take = 1'b0;
        unique case (state_q)
            S_TOP, S_LEFT, S_RIGHT, S_BOTTOM: beat = advance;
            S_BODY: begin
                take = advance;
                beat = advance & bus.i_valid;
            end
            default: ;
        endcase

        bus.o_ready = take & ~reset;

        valid_d = beat;
        y_d     = (beat && (state_q == S_BODY)) ? bus.i_x : '0;
        last_d  = beat & col_last & row_last;

        // Position only moves with a beat, so input bubbles never skip a column.
        col_d = col_q;
        row_d = row_q;
        if (beat) begin
            col_d = col_last ? '0 : col_q + COL_W'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Position counters and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            last_q  <= 1'b0;
        end else if (advance) begin
            valid_q <= valid_d;
            y_q     <= y_d;
            last_q  <= last_d;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_y     = y_q;
    assign bus.o_last  = last_q;

    // ------------------------------------------------------------------
    // Interface invariants
    // ------------------------------------------------------------------
    a_hold_on_stall: assert property (@(posedge clk) disable iff (reset)
        (bus.o_valid && !bus.i_ready) |=>
            (bus.o_valid && $stable(bus.o_y) && $stable(bus.o_last)));

    a_ready_only_in_body: assert property (@(posedge clk) disable iff (reset)
        bus.o_ready |-> (state_q == S_BODY));

    a_last_with_valid: assert property (@(posedge clk) disable iff (reset)
        bus.o_last |-> bus.o_valid);

endmodule

// File: tb/tb_pad_stream_gen.sv
module tb_pad_stream_gen;
    import pad_stream_gen_pkg::*;

    localparam int A_W = 4;
    localparam int A_H = 2;
    localparam int A_P = 1;
    localparam int B_W = 3;
    localparam int B_H = 1;
    localparam int B_P = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pad_stream_gen_if bus_a ();
    pad_stream_gen_if bus_b ();

    pad_stream_gen #(.IMG_W(A_W), .IMG_H(A_H), .PAD(A_P)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pad_stream_gen #(.IMG_W(B_W), .IMG_H(B_H), .PAD(B_P)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    int errors = 0;
    int checks = 0;

    // Model: expected padded beats {last, pixel}, and what was observed.
    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    logic [7:0] obs_a[$];
    logic [7:0] obs_b[$];
    logic       obs_last_a[$];
    int         xfer_a[$];
    int         beats_a = 0;
    int         cyc = 0;

    logic       stall_prev[2];
    logic [7:0] stall_y[2];
    logic       stall_last[2];

    int   ready_mode = 0;
    logic ready_tog  = 1'b1;
    bit   abort      = 1'b0;

    logic [7:0] pix_buf[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected padded frame straight from the border rule.
    task automatic push_frame(input int id, input int w, input int h, input int p,
                              input logic [7:0] pix[$]);
        logic [8:0] e;
        for (int r = 0; r < h + 2 * p; r++) begin
            for (int c = 0; c < w + 2 * p; c++) begin
                e[7:0] = (r >= p && r < p + h && c >= p && c < p + w) ?
                         pix[(r - p) * w + (c - p)] : 8'h00;
                e[8]   = (r == h + 2 * p - 1) && (c == w + 2 * p - 1);
                if (id == 0) exp_a.push_back(e);
                else         exp_b.push_back(e);
            end
        end
    endtask

    task automatic observe(input int id, input logic v, input logic r, input logic [7:0] y,
                           input logic l, input logic ordy);
        logic [8:0] e;
        bit have;
        if (reset) begin
            check($sformatf("o_ready_in_reset_%0d", id), ordy, 0);
            stall_prev[id] = 1'b0;
            return;
        end
        if (stall_prev[id]) begin
            check($sformatf("hold_valid_%0d", id), v, 1);
            check($sformatf("hold_y_%0d", id), y, stall_y[id]);
            check($sformatf("hold_last_%0d", id), l, stall_last[id]);
        end
        stall_prev[id] = v && !r;
        stall_y[id]    = y;
        stall_last[id] = l;
        if (v && r) begin
            have = 1'b0;
            e    = '0;
            if (id == 0 && exp_a.size() > 0) begin
                e = exp_a.pop_front();
                have = 1'b1;
            end
            if (id == 1 && exp_b.size() > 0) begin
                e = exp_b.pop_front();
                have = 1'b1;
            end
            check($sformatf("beat_expected_%0d", id), have, 1);
            if (have) begin
                check($sformatf("beat_y_%0d", id), y, e[7:0]);
                check($sformatf("beat_last_%0d", id), l, e[8]);
            end
            if (id == 0) begin
                obs_a.push_back(y);
                obs_last_a.push_back(l);
                xfer_a.push_back(cyc);
                beats_a++;
            end else begin
                obs_b.push_back(y);
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        observe(0, bus_a.o_valid, bus_a.i_ready, bus_a.o_y, bus_a.o_last, bus_a.o_ready);
        observe(1, bus_b.o_valid, bus_b.i_ready, bus_b.o_y, bus_b.o_last, bus_b.o_ready);
    end

    always @(posedge clk) begin
        #1;
        ready_tog = ~ready_tog;
        case (ready_mode)
            0:       bus_a.i_ready = 1'b1;
            1:       bus_a.i_ready = ready_tog;
            default: bus_a.i_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic set_in(input int id, input logic v, input logic [7:0] x);
        if (id == 0) begin
            bus_a.i_valid = v;
            bus_a.i_x     = x;
        end else begin
            bus_b.i_valid = v;
            bus_b.i_x     = x;
        end
    endtask

    // gap_mode: 0 none, 1 three idle cycles after pixels 2 and 6, 2 random gaps.
    task automatic send_frame(input int id, input logic [7:0] pix[$], input int gap_mode);
        int   n;
        logic rdy;
        if (id == 0) push_frame(0, A_W, A_H, A_P, pix);
        else         push_frame(1, B_W, B_H, B_P, pix);
        foreach (pix[k]) begin
            set_in(id, 1'b1, pix[k]);
            n   = 0;
            rdy = 1'b0;
            while (!rdy && !abort && n < 500) begin
                @(negedge clk);
                n++;
                rdy = (id == 0) ? bus_a.o_ready : bus_b.o_ready;
            end
            if (abort) begin
                set_in(id, 1'b0, 8'h00);
                return;
            end
            if (!rdy) begin
                check($sformatf("input_accepted_%0d", id), rdy, 1);
                set_in(id, 1'b0, 8'h00);
                return;
            end
            @(posedge clk);
            #1;
            if ((gap_mode == 1 && (k == 1 || k == 5)) ||
                (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                set_in(id, 1'b0, 8'hEE);
                repeat ((gap_mode == 1) ? 3 : $urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        set_in(id, 1'b0, 8'h00);
    endtask

    task automatic drain(input int id);
        int n = 0;
        while (((id == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check($sformatf("drained_%0d", id), (id == 0) ? exp_a.size() : exp_b.size(), 0);
    endtask

    task automatic seq_pix(input int start, input int n);
        pix_buf.delete();
        for (int i = 0; i < n; i++) pix_buf.push_back(8'(start + i));
    endtask

    task automatic clear_obs();
        obs_a.delete();
        obs_last_a.delete();
        xfer_a.delete();
    endtask

    task automatic check_frame_a(input string name, input int base, input int add);
        logic [7:0] lit[24] = '{0, 0, 0, 0, 0, 0,  0, 1, 2, 3, 4, 0,
                                0, 5, 6, 7, 8, 0,  0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 24; i++) begin
            if (base + i < obs_a.size()) begin
                check($sformatf("%s_y%0d", name, i), obs_a[base + i],
                      (lit[i] == 0) ? 8'h00 : 8'(lit[i] + add));
                check($sformatf("%s_last%0d", name, i), obs_last_a[base + i], i == 23);
            end
        end
    endtask

    initial begin
        int n;
        int b0;
        int zsum;
        logic [7:0] row2[7] = '{0, 0, 7, 8, 9, 0, 0};

        for (int i = 0; i < 2; i++) stall_prev[i] = 1'b0;
        bus_a.i_valid = 1'b0;
        bus_a.i_x     = 8'h00;
        bus_b.i_valid = 1'b0;
        bus_b.i_x     = 8'h00;
        bus_b.i_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_o_valid", bus_a.o_valid, 0);
        check("reset_o_y", bus_a.o_y, 0);
        check("reset_o_last", bus_a.o_last, 0);
        check("reset_o_ready", bus_a.o_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1. Single frame, sink always ready
        ready_mode = 0;
        clear_obs();
        seq_pix(1, 8);
        send_frame(0, pix_buf, 0);
        drain(0);
        check("t1_beats", obs_a.size(), 24);
        check_frame_a("t1", 0, 0);

        // 2. Sink toggling
        ready_mode = 1;
        clear_obs();
        send_frame(0, pix_buf, 0);
        drain(0);
        check("t2_beats", obs_a.size(), 24);
        check_frame_a("t2", 0, 0);

        // 3. Input gaps
        ready_mode = 0;
        clear_obs();
        send_frame(0, pix_buf, 1);
        drain(0);
        check("t3_beats", obs_a.size(), 24);
        check_frame_a("t3", 0, 0);

        // 4. Two frames back to back
        clear_obs();
        seq_pix(1, 8);
        send_frame(0, pix_buf, 0);
        seq_pix(9, 8);
        send_frame(0, pix_buf, 0);
        drain(0);
        check("t4_beats", obs_a.size(), 48);
        check_frame_a("t4a", 0, 0);
        check_frame_a("t4b", 24, 8);
        if (xfer_a.size() >= 25) check("t4_idle_gap", xfer_a[24] - xfer_a[23], 2);
        else check("t4_gap_samples", xfer_a.size(), 25);

        // 5. Reset mid-frame
        clear_obs();
        seq_pix(1, 8);
        b0 = beats_a;
        fork
            send_frame(0, pix_buf, 0);
        join_none
        n = 0;
        while (beats_a - b0 < 10 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("t5_reached_beat10", beats_a - b0 >= 10, 1);
        #1;
        reset = 1'b1;
        abort = 1'b1;
        exp_a.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait fork;
        abort = 1'b0;
        @(negedge clk);
        check("t5_post_reset_valid", bus_a.o_valid, 0);
        check("t5_post_reset_last", bus_a.o_last, 0);
        @(posedge clk);
        #1;
        clear_obs();
        seq_pix(21, 8);
        send_frame(0, pix_buf, 0);
        drain(0);
        check("t5_beats", obs_a.size(), 24);
        check_frame_a("t5", 0, 20);

        // 6. PAD=2, 3x1 image
        obs_b.delete();
        pix_buf.delete();
        pix_buf.push_back(8'd7);
        pix_buf.push_back(8'd8);
        pix_buf.push_back(8'd9);
        send_frame(1, pix_buf, 0);
        drain(1);
        check("t6_beats", obs_b.size(), 35);
        zsum = 0;
        for (int i = 0; i < obs_b.size(); i++) begin
            if (i >= 14 && i < 21) check($sformatf("t6_row2_%0d", i - 14), obs_b[i], row2[i - 14]);
            else zsum += int'(obs_b[i]);
        end
        check("t6_border_sum", zsum, 0);

        // 7. Random pixels, random gaps, random sink stalls
        ready_mode = 2;
        clear_obs();
        for (int f = 0; f < 4; f++) begin
            pix_buf.delete();
            for (int i = 0; i < A_W * A_H; i++) pix_buf.push_back(8'($urandom_range(0, 255)));
            send_frame(0, pix_buf, 2);
        end
        drain(0);
        check("t7_beats", obs_a.size(), 96);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
